// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin shared-bus interconnect with address decode and
// single-cycle response routing back to the granted host.
module bus_rr_arbiter #(
    parameter int NrHosts      = 2,
    parameter int NrDevices    = 3,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_base_i,
    input  logic [NrDevices*AddressWidth-1:0] cfg_device_addr_mask_i,
    input  logic [NrHosts-1:0]                host_req_i,
    output logic [NrHosts-1:0]                host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]    host_be_i,
    input  logic [NrHosts*DataWidth-1:0]      host_wdata_i,
    output logic [NrHosts-1:0]                host_rvalid_o,
    output logic [NrHosts*DataWidth-1:0]      host_rdata_o,
    output logic [NrHosts-1:0]                host_err_o,
    output logic [NrDevices-1:0]              device_req_o,
    output logic [AddressWidth-1:0]           device_addr_o,
    output logic                              device_we_o,
    output logic [DataWidth/8-1:0]            device_be_o,
    output logic [DataWidth-1:0]              device_wdata_o,
    input  logic [NrDevices-1:0]              device_rvalid_i,
    input  logic [NrDevices*DataWidth-1:0]    device_rdata_i,
    input  logic [NrDevices-1:0]              device_err_i
);
    localparam int HW = NrHosts > 1 ? $clog2(NrHosts) : 1;
    localparam int DIW = NrDevices > 1 ? $clog2(NrDevices) : 1;
    localparam int BW = DataWidth / 8;

    logic [HW-1:0]  rr_ptr_q, winner, resp_host_q;
    logic [DIW-1:0] dev_idx, resp_dev_q;
    logic           gnt, hit, resp_vld_q, resp_unmap_q, rv, err;
    logic [DataWidth-1:0] rdata;
    int             j;

    // Reset forces every grant-side output low by suppressing the grant itself.
    always_comb begin
        gnt = 1'b0;
        winner = '0;
        j = 0;
        device_addr_o = '0;
        device_we_o = 1'b0;
        device_be_o = '0;
        device_wdata_o = '0;
        for (int i = 0; i < NrHosts; i++) begin
            j = (int'(rr_ptr_q) + i) % NrHosts;
            if (!rst_i && !gnt && host_req_i[j]) begin
                gnt = 1'b1;
                winner = HW'(j);
                device_addr_o = host_addr_i[j*AddressWidth +: AddressWidth];
                device_we_o = host_we_i[j];
                device_be_o = host_be_i[j*BW +: BW];
                device_wdata_o = host_wdata_i[j*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        dev_idx = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if (!hit && ((device_addr_o & cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth]) ==
                         (cfg_device_addr_base_i[d*AddressWidth +: AddressWidth] &
                          cfg_device_addr_mask_i[d*AddressWidth +: AddressWidth]))) begin
                hit = 1'b1;
                dev_idx = DIW'(d);
            end
        end
        host_gnt_o = '0;
        device_req_o = '0;
        if (gnt) host_gnt_o[winner] = 1'b1;
        if (gnt && hit) device_req_o[dev_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            resp_vld_q <= 1'b0;
            resp_host_q <= '0;
            resp_dev_q <= '0;
            resp_unmap_q <= 1'b0;
        end else begin
            resp_vld_q <= gnt;
            if (gnt) begin
                rr_ptr_q <= winner == HW'(NrHosts - 1) ? '0 : winner + 1'b1;
                resp_host_q <= winner;
                resp_dev_q <= dev_idx;
                resp_unmap_q <= !hit;
            end
        end
    end

    // Only the device captured at grant may answer; stray rvalids are ignored.
    always_comb begin
        rv = resp_unmap_q ? 1'b1 : device_rvalid_i[resp_dev_q];
        err = resp_unmap_q ? 1'b1 : device_rvalid_i[resp_dev_q] & device_err_i[resp_dev_q];
        rdata = (resp_unmap_q || !rv) ? '0 : device_rdata_i[int'(resp_dev_q)*DataWidth +: DataWidth];
        host_rvalid_o = '0;
        host_err_o = '0;
        host_rdata_o = '0;
        if (resp_vld_q && !rst_i) begin
            host_rvalid_o[resp_host_q] = rv;
            host_err_o[resp_host_q] = err;
            host_rdata_o[int'(resp_host_q)*DataWidth +: DataWidth] = rdata;
        end
    end
endmodule
